// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared geometry constants and types for the tile framebuffer arbiter
package vga_fb_pkg;
    localparam int FB_W     = 80;
    localparam int FB_H     = 60;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 13;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        rgb332_t           data;
    } wr_req_t;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} arb_state_t;
endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// fb_wr_fifo: synchronous FIFO of pending tile writes with full/empty flags
module fb_wr_fifo import vga_fb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wr_req_t din,
    output wr_req_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    wr_req_t mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = wp == {~rp[AW], rp[AW-1:0]};
    assign do_pop  = pop && !empty;
    // a full FIFO still takes a push when the same cycle frees a slot
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= do_push ? wp + ONE : wp;
            rp <= do_pop ? rp + ONE : rp;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port tile framebuffer between VGA scanout reads,
// buffered pixel writes and a full-buffer clear engine; scanout always wins the port.
module vga_fb_arbiter #(
    parameter int FB_W        = vga_fb_pkg::FB_W,
    parameter int FB_H        = vga_fb_pkg::FB_H,
    parameter int TILE_SHIFT  = 3,
    parameter int ACTIVE_HORI = 640,
    parameter int ACTIVE_VERT = 480,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic [9:0]  hori_cnt,
    input  logic [9:0]  vert_cnt,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clear_req,
    input  logic [7:0]  clear_color,
    output logic        clear_busy,
    output logic        addr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  rgb_out
);
    import vga_fb_pkg::arb_state_t, vga_fb_pkg::wr_req_t, vga_fb_pkg::rgb332_t;
    import vga_fb_pkg::IDLE, vga_fb_pkg::DRAIN, vga_fb_pkg::CLEAR;

    localparam int DEPTH = FB_W * FB_H;
    localparam logic [12:0] LAST = 13'(DEPTH - 1);

    arb_state_t state, state_n;
    wr_req_t fifo_dout;
    rgb332_t clr_color, clr_color_n;
    logic [12:0] clr_addr, clr_addr_n, rd_addr;
    logic tick_d1, slot, slot_d1, blank_d1, push, pop, full, empty, err_set;

    assign slot = !reset && tick_d1 && hori_cnt < 10'(ACTIVE_HORI) && vert_cnt < 10'(ACTIVE_VERT);
    assign rd_addr = 13'(32'(vert_cnt >> TILE_SHIFT) * FB_W + 32'(hori_cnt >> TILE_SHIFT));
    // clear_req blocks the handshake so a write presented alongside it is not taken
    assign wr_ready = !reset && !full && state == IDLE && !clear_req;
    assign push = wr_valid && wr_ready;
    assign clear_busy = state != IDLE;

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wr_addr, wr_data}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        clr_addr_n = clr_addr;
        clr_color_n = clr_color;
        pop = 1'b0;
        err_set = 1'b0;
        mem_en = 1'b0;
        mem_we = 1'b0;
        mem_addr = rd_addr;
        mem_wdata = clr_color;
        if (slot) begin
            mem_en = 1'b1;
        end else if (!reset && state == CLEAR) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            mem_addr = clr_addr;
            clr_addr_n = clr_addr == LAST ? 13'd0 : clr_addr + 13'd1;
            state_n = clr_addr == LAST ? IDLE : CLEAR;
        end else if (!reset && !empty) begin
            pop = 1'b1;
            mem_en = fifo_dout.addr < 13'(DEPTH);
            mem_we = mem_en;
            err_set = !mem_en;
            mem_addr = fifo_dout.addr;
            mem_wdata = fifo_dout.data;
        end
        if (state == IDLE && clear_req) begin
            state_n = DRAIN;
            clr_color_n = clear_color;
            clr_addr_n = 13'd0;
        end
        if (state == DRAIN && empty) state_n = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            clr_addr <= '0;
            clr_color <= '0;
            tick_d1 <= 1'b0;
            slot_d1 <= 1'b0;
            blank_d1 <= 1'b0;
            rgb_out <= '0;
            addr_err <= 1'b0;
        end else begin
            state <= state_n;
            clr_addr <= clr_addr_n;
            clr_color <= clr_color_n;
            tick_d1 <= pixel_tick;
            slot_d1 <= slot;
            blank_d1 <= tick_d1 && !slot;
            rgb_out <= slot_d1 ? mem_rdata : blank_d1 ? 8'h00 : rgb_out;
            addr_err <= addr_err | err_set;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench; expected reads, pixels and RAM writes are
// queued by the stimulus and matched by a monitor against the DUT's RAM port.
module tb_vga_fb_arbiter;
    logic clk = 0, reset = 1, pixel_tick = 0, wr_valid = 0, clear_req = 0;
    logic [9:0] hori_cnt = 0, vert_cnt = 0;
    logic [12:0] wr_addr = 0, mem_addr;
    logic [7:0] wr_data = 0, clear_color = 0, mem_wdata, rgb_out;
    logic [7:0] mem_rdata = 0;
    logic wr_ready, clear_busy, addr_err, mem_en, mem_we;

    typedef struct { int due; int addr; } rd_exp_t;
    typedef struct { int due; int color; bit chk; } px_exp_t;
    typedef struct { int addr; int data; } wr_exp_t;
    rd_exp_t rq[$];
    px_exp_t pq[$];
    wr_exp_t wq[$];
    logic [7:0] ram [8192];
    int ref_fb [4800];
    int cyc = 0, checks = 0, errors = 0, clr_seen = -1;
    bit exp_err = 0, chk_color = 1;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .hori_cnt(hori_cnt),
        .vert_cnt(vert_cnt), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .addr_err(addr_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("slot_read", int'({mem_en, mem_we, mem_addr}), int'({2'b10, 13'(rq[0].addr)}));
                void'(rq.pop_front());
            end else begin
                chk("no_stray_read", int'(mem_en && !mem_we), 0);
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                if (pq[0].chk) chk("rgb_out", int'(rgb_out), pq[0].color);
                void'(pq.pop_front());
            end
            if (mem_en && mem_we) begin
                chk("write_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    chk("write", int'({mem_addr, mem_wdata}), int'({13'(wq[0].addr), 8'(wq[0].data)}));
                    void'(wq.pop_front());
                end
                if (clear_busy) clr_seen = int'(mem_addr);
            end
        end
    end

    // one pixel per period: tick, then counters step; slot follows, pixel 2 clk later
    task automatic scan(input int h0, input int v0, input int n, input int per);
        int h = h0;
        int v = v0;
        for (int i = 0; i < n; i++) begin
            pixel_tick = 1;
            @(posedge clk); #1;
            pixel_tick = 0;
            hori_cnt = 10'(h);
            vert_cnt = 10'(v);
            if (h < 640 && v < 480) begin
                rq.push_back('{cyc, (v / 8) * 80 + h / 8});
                pq.push_back('{cyc + 2, ref_fb[(v / 8) * 80 + h / 8], chk_color});
            end else begin
                pq.push_back('{cyc + 2, 0, 1'b1});
            end
            h = (h == 799) ? 0 : h + 1;
            if (h == 0) v = (v == 524) ? 0 : v + 1;
            repeat (per - 1) @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int d);
        bit acc = 0;
        wr_valid = 1;
        wr_addr = 13'(a);
        wr_data = 8'(d);
        for (int t = 0; t < 20000 && !acc; t++) begin
            @(negedge clk);
            if (wr_ready) begin
                acc = 1;
                if (a < 4800) begin
                    wq.push_back('{a, d});
                    ref_fb[a] = d;
                end else begin
                    exp_err = 1;
                end
            end
            @(posedge clk); #1;
        end
        wr_valid = 0;
        chk("wr_accepted", int'(acc), 1);
    endtask

    task automatic rand_writes(input int n);
        for (int i = 0; i < n; i++) begin
            int a = ($urandom_range(7) == 0) ? int'($urandom_range(8191, 4800)) : int'($urandom_range(4799, 160));
            int g = int'($urandom_range(3));
            wr(a, int'($urandom_range(255)));
            repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic start_clear(input int color);
        clear_req = 1;
        clear_color = 8'(color);
        wr_valid = 1;
        wr_addr = 13'd20;
        wr_data = 8'hFF;
        @(negedge clk);
        chk("ready_low_on_clear", int'(wr_ready), 0);
        for (int i = 0; i < 4800; i++) begin
            wq.push_back('{i, color});
            ref_fb[i] = color;
        end
        @(posedge clk); #1;
        clear_req = 0;
        wr_valid = 0;
        @(negedge clk);
        chk("busy_after_req", int'(clear_busy), 1);
        chk("ready_low_busy", int'(wr_ready), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (clear_busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("clear_done_in_time", int'(clear_busy), 0);
        chk("ready_after_clear", int'(wr_ready), 1);
        chk("clear_all_written", wq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
        ram[0] = 8'hE0;
        ram[1] = 8'h1C;
        for (int i = 0; i < 4800; i++) ref_fb[i] = int'(ram[i]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_busy", int'(clear_busy), 0);
        chk("rst_err", int'(addr_err), 0);
        chk("rst_en", int'(mem_en), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_rgb", int'(rgb_out), 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("ready_after_reset", int'(wr_ready), 1);
        @(posedge clk); #1;

        scan(0, 0, 16, 4);
        fork
            scan(630, 0, 30, 3);
            begin wr(200, 8'h11); wr(201, 8'h22); end
        join
        fork
            scan(0, 0, 40, 4);
            begin for (int i = 0; i < 4; i++) wr(100 + i, 8'h55); end
        join
        wr(4800, 8'hAA);
        repeat (10) begin @(posedge clk); #1; end
        chk("addr_err_set", int'(addr_err), 1);
        chk("writes_drained", wq.size(), 0);

        for (int r = 0; r < 6; r++) begin
            fork
                scan(int'($urandom_range(700)), int'($urandom_range(14)), int'($urandom_range(60, 20)), int'($urandom_range(6, 3)));
                rand_writes(12);
            join
            repeat (10) begin @(posedge clk); #1; end
            chk("rand_drained", wq.size(), 0);
            chk("addr_err_sticky", int'(addr_err), int'(exp_err));
        end

        chk_color = 0;
        fork
            scan(0, 0, 2600, 3);
            begin
                wr(10, 8'h01); wr(11, 8'h02); wr(12, 8'h04);
                start_clear(8'h03);
                wait_idle();
            end
        join
        chk_color = 1;
        repeat (5) begin @(posedge clk); #1; end
        scan(0, 0, 20, 4);
        scan(0, 8, 10, 5);
        chk("err_kept_through_clear", int'(addr_err), 1);

        clr_seen = -1;
        start_clear(8'hC3);
        for (int t = 0; t < 20000 && clr_seen < 2000; t++) begin @(posedge clk); #1; end
        chk("clear_reached_2000", int'(clr_seen >= 2000), 1);
        reset = 1;
        wq.delete();
        rq.delete();
        pq.delete();
        exp_err = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("reset_busy", int'(clear_busy), 0);
        chk("reset_ready", int'(wr_ready), 1);
        chk("reset_err", int'(addr_err), 0);
        chk("reset_we", int'(mem_we), 0);
        repeat (30) begin @(posedge clk); #1; end
        wr(300, 8'h77);
        repeat (5) begin @(posedge clk); #1; end
        chk("post_reset_write", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
